// File: rtl/prog_loader.sv
// Byte-stream loader for the instruction memory: packs {HI,LO} byte pairs into words and holds the core while loading.
// Optional feature macro CHECKSUM_EN adds a trailing XOR checksum byte over LEN and all HI/LO bytes.
module prog_loader #(
  parameter int ADDR_W = 5,
  parameter int INST_W = 13,
  parameter int DEPTH  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [INST_W-1:0]   imem_wdata,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     word_count
);

  localparam int HI_W = INST_W - 8;
  localparam logic [8:0] DEPTH_C = 9'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WRITE,
`ifdef CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [ADDR_W:0] count_inc;
  logic [HI_W-1:0] hi_q, hi_d;
  logic [7:0]      lo_q, lo_d;
  logic            xfer;

  // A byte moves only on valid && ready; ready is a pure function of state.
  always_comb begin
    byte_ready = (state_q == S_LEN) || (state_q == S_HI) || (state_q == S_LO)
`ifdef CHECKSUM_EN
                 || (state_q == S_CHK)
`endif
                 ;
  end

  assign xfer       = byte_valid && byte_ready;
  assign count_inc  = count_q + 1'b1;
  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = count_q[ADDR_W-1:0];
  assign imem_wdata = {hi_q, lo_q};
  assign word_count = count_q;
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign busy       = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  // ERR keeps the core held so a partial image never runs.
  assign cpu_hold   = busy || (state_q == S_ERR);

`ifdef CHECKSUM_EN
  logic [7:0] xor_q, xor_d;

  always_comb begin
    xor_d = xor_q;
    if (xfer) begin
      case (state_q)
        S_LEN:      xor_d = byte_in;
        S_HI, S_LO: xor_d = xor_q ^ byte_in;
        default:    xor_d = xor_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) xor_q <= '0;
    else        xor_q <= xor_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          count_d = '0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          if ((byte_in == 8'd0) || ({1'b0, byte_in} > DEPTH_C)) begin
            state_d = S_ERR;
          end else begin
            len_d   = byte_in[ADDR_W:0];
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        if (xfer) begin
          if (|byte_in[7:HI_W]) begin
            state_d = S_ERR;
          end else begin
            hi_d    = byte_in[HI_W-1:0];
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (xfer) begin
          lo_d    = byte_in;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        count_d = count_inc;
        if (count_inc == len_q) begin
`ifdef CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_HI;
        end
      end
`ifdef CHECKSUM_EN
      S_CHK: begin
        if (xfer) state_d = (byte_in == xor_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a stream model predicts imem writes, final status and word count.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [12:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [5:0]  word_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [17:0] exp_q[$];
  logic [12:0] words[32];

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every write must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (reset && imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {14'd0, imem_addr, imem_wdata}, 32'hFFFF_FFFF);
      end else begin
        check("imem_write", {14'd0, imem_addr, imem_wdata}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (byte_ready) break;
      waited++;
      if (waited > 50) begin
        check("ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_in    = $urandom_range(0, 255);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_outcome();
    int k;
    k = 0;
    while (!(done || err) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("outcome_timeout", 32'd0, 32'd1);
  endtask

  // Model: a load of n words from words[]; bad_idx >= 0 sets a reserved HI bit on that word.
  task automatic do_load(input int n, input int bad_idx, input bit bad_chk, input bit mid_start);
    logic [7:0] csum, hi, lo;
    bit exp_err;
    int exp_wc;
    exp_err = 1'b0;
    exp_wc  = 0;
    pulse_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_hold", {31'd0, cpu_hold}, 32'd1);
    check("start_flags", {30'd0, done, err}, 32'd0);
    check("start_count", {26'd0, word_count}, 32'd0);
    csum = 8'(n);
    send_byte(8'(n));
    if (n == 0 || n > 32) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) begin
        hi = {3'b000, words[i][12:8]};
        lo = words[i][7:0];
        if (i == bad_idx) begin
          send_byte(hi | 8'h20);
          exp_err = 1'b1;
          break;
        end
        send_byte(hi);
        exp_q.push_back({5'(i), words[i]});
        send_byte(lo);
        csum = csum ^ hi ^ lo;
        @(negedge clk);
        check("we_latency", {31'd0, imem_we}, 32'd1);
        exp_wc = i + 1;
        if (mid_start && i == 0) begin
          pulse_start();
          check("start_ignored", {31'd0, busy}, 32'd1);
        end
        gap();
      end
    end
`ifdef CHECKSUM_EN
    if (!exp_err) begin
      send_byte(bad_chk ? (csum ^ 8'h01) : csum);
      if (bad_chk) exp_err = 1'b1;
    end
`else
    if (bad_chk) exp_err = 1'b1;
`endif
    wait_outcome();
    check("end_done", {31'd0, done}, {31'd0, !exp_err});
    check("end_err", {31'd0, err}, {31'd0, exp_err});
    check("end_hold", {31'd0, cpu_hold}, {31'd0, exp_err});
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_ready", {31'd0, byte_ready}, 32'd0);
    check("end_count", {26'd0, word_count}, 32'(exp_wc));
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h55;
    byte_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Idle with a byte offered: nothing may move.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, byte_ready}, 32'd0);
      check("idle_outputs", {18'd0, imem_we, cpu_hold, busy, done, err, word_count, 3'd0}, 32'd0);
      check("idle_addr_data", {14'd0, imem_addr, imem_wdata}, 32'd0);
    end
    byte_valid = 1'b0;

    words[0] = 13'h1FFF;
    words[1] = 13'h003C;
    do_load(2, -1, 1'b0, 1'b0);

    do_load(0, -1, 1'b0, 1'b0);
    words[0] = 13'(($urandom_range(0, 8191)));
    do_load(1, -1, 1'b0, 1'b0);

    words[0] = 13'h0000;
    do_load(1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 32; i++) words[i] = 13'(i);
    do_load(32, -1, 1'b0, 1'b0);
    do_load(33, -1, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int n;
      int bad;
      n = $urandom_range(1, 32);
      for (int i = 0; i < 32; i++) words[i] = 13'($urandom_range(0, 8191));
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      do_load(n, bad, 1'b0, ($urandom_range(0, 1) == 1));
    end

`ifdef CHECKSUM_EN
    words[0] = 13'h0ABC;
    do_load(1, -1, 1'b1, 1'b0);
`endif

    // Reset in the middle of a 5-word load, after the third write.
    for (int i = 0; i < 5; i++) words[i] = 13'($urandom_range(0, 8191));
    pulse_start();
    send_byte(8'd5);
    for (int i = 0; i < 3; i++) begin
      send_byte({3'b000, words[i][12:8]});
      exp_q.push_back({5'(i), words[i]});
      send_byte(words[i][7:0]);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_count", {26'd0, word_count}, 32'd0);
    check("rst_written", 32'(exp_q.size()), 32'd0);
    byte_in    = 8'h00;
    byte_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("post_rst_idle", {29'd0, busy, done, err}, 32'd0);
    check("post_rst_hold", {31'd0, cpu_hold}, 32'd0);
    byte_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
